// File: rtl/v810_pkg.sv
// Shared types and helpers for the v810 write buffer: the slot record and
// the byte-enable rules that decide whether two writes may be merged.
package v810_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  bc;
        logic [3:0]  be;
        logic        mrq;
        logic [1:0]  st;
    } wbuf_ent_t;

    // Merged enables must form a byte, an aligned halfword or a full word.
    function automatic logic be_merge_ok(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] be_to_bc(input logic [3:0] be);
        logic [2:0] n;
        n = {2'b00, be[0]} + {2'b00, be[1]} + {2'b00, be[2]} + {2'b00, be[3]};
        return 2'(n - 3'd1);
    endfunction

endpackage

// File: rtl/v810_wbuf_fwd.sv
// Read-probe lookup over the occupied write-buffer slots; the youngest
// matching entry decides between a forward hit and a conflict.
module v810_wbuf_fwd #(
    parameter int DEPTH  = 4,
    parameter int FWD_EN = 1
) (
    input  logic [29:0]              ent_wa  [DEPTH],
    input  logic [31:0]              ent_d   [DEPTH],
    input  logic [3:0]               ent_be  [DEPTH],
    input  logic                     ent_mrq [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic                     rd_req,
    input  logic [29:0]              rd_wa,
    input  logic [3:0]               rd_be,
    output logic                     hit,
    output logic [31:0]              rd_d,
    output logic                     conflict
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;
    logic          match;
    logic [3:0]    m_be;
    logic [31:0]   m_d;
    logic          covers;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        idx   = '0;
        match = 1'b0;
        m_be  = '0;
        m_d   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((k < int'(count)) && ent_mrq[idx] && (ent_wa[idx] == rd_wa)) begin
                match = 1'b1;
                m_be  = ent_be[idx];
                m_d   = ent_d[idx];
            end
        end
    end

    assign covers = ((m_be & rd_be) == rd_be);

    always_comb begin
        hit      = 1'b0;
        conflict = 1'b0;
        rd_d     = m_d;
        if (FWD_EN != 0) begin
            hit      = rd_req & match & covers;
            conflict = rd_req & match & ~covers;
        end else begin
            conflict = rd_req & match;
        end
    end

endmodule

// File: rtl/v810_wbuf.sv
// Posted-write buffer: circular FIFO of pending writes with byte-merge into
// the newest entry and a read probe that forwards or flags conflicts.
module v810_wbuf
    import v810_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MERGE_EN = 1,
    parameter int FWD_EN   = 1
) (
    input  logic                   CLK,
    input  logic                   RESn,
    input  logic                   CE,
    input  logic [31:0]            IN_A,
    input  logic [31:0]            IN_D,
    input  logic [1:0]             IN_BC,
    input  logic [3:0]             IN_BE,
    input  logic                   IN_MRQ,
    input  logic [1:0]             IN_ST,
    input  logic                   IN_REQ,
    output logic                   IN_ACK,
    input  logic [31:0]            RD_A,
    input  logic [3:0]             RD_BE,
    input  logic                   RD_REQ,
    output logic                   RD_HIT,
    output logic [31:0]            RD_D,
    output logic                   RD_CONFLICT,
    output logic [31:0]            OUT_A,
    output logic [31:0]            OUT_D,
    output logic [1:0]             OUT_BC,
    output logic [3:0]             OUT_BE,
    output logic                   OUT_MRQ,
    output logic [1:0]             OUT_ST,
    output logic                   OUT_VALID,
    input  logic                   OUT_ACK,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic [$clog2(DEPTH):0] COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbuf_ent_t     ent [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, newest;
    logic [CW-1:0] count, count_nxt;
    logic          empty, full;

    logic          pop_req, merge_hit;
    logic          do_push, do_pop, do_merge;
    logic [3:0]    be_or;
    logic [31:0]   merged_d;

    assign newest  = wr_ptr - 1'b1;
    assign be_or   = ent[newest].be | IN_BE;
    assign pop_req = ~empty & OUT_ACK;

    // With two or more entries the newest is never the head, so merging it
    // cannot disturb an entry that is being presented or popped.
    assign merge_hit = (MERGE_EN != 0) && (count >= CW'(2))
                    && (ent[newest].a[31:2] == IN_A[31:2])
                    && (ent[newest].mrq == IN_MRQ)
                    && (ent[newest].st == IN_ST)
                    && be_merge_ok(be_or);

    assign IN_ACK   = IN_REQ & RESn & (merge_hit | ~full | pop_req);
    assign do_push  = CE & IN_ACK & ~merge_hit;
    assign do_merge = CE & IN_ACK & merge_hit;
    assign do_pop   = CE & RESn & pop_req;

    always_comb begin
        merged_d = ent[newest].d;
        for (int b = 0; b < 4; b++) begin
            if (IN_BE[b]) merged_d[8*b +: 8] = IN_D[8*b +: 8];
        end
    end

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)      count_nxt = count + 1'b1;
        else if (!do_push && do_pop) count_nxt = count - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (CE) begin
            if (!RESn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                empty  <= 1'b1;
                full   <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count_nxt;
                empty <= (count_nxt == '0);
                full  <= (count_nxt == CW'(DEPTH));
            end
        end
    end

    // Slot contents carry no reset; occupancy alone defines validity.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            ent[wr_ptr] <= '{a: IN_A, d: IN_D, bc: IN_BC, be: IN_BE, mrq: IN_MRQ, st: IN_ST};
        end else if (do_merge) begin
            ent[newest].be <= be_or;
            ent[newest].bc <= be_to_bc(be_or);
            ent[newest].d  <= merged_d;
        end
    end

    assign OUT_A     = ent[rd_ptr].a;
    assign OUT_D     = ent[rd_ptr].d;
    assign OUT_BC    = ent[rd_ptr].bc;
    assign OUT_BE    = ent[rd_ptr].be;
    assign OUT_MRQ   = ent[rd_ptr].mrq;
    assign OUT_ST    = ent[rd_ptr].st;
    assign OUT_VALID = ~empty;
    assign EMPTY     = empty;
    assign FULL      = full;
    assign COUNT     = count;

    logic [29:0] fw_wa  [DEPTH];
    logic [31:0] fw_d   [DEPTH];
    logic [3:0]  fw_be  [DEPTH];
    logic        fw_mrq [DEPTH];
    logic        fw_hit, fw_conflict;
    logic        unused_rd_lsb;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fw_wa[i]  = ent[i].a[31:2];
            fw_d[i]   = ent[i].d;
            fw_be[i]  = ent[i].be;
            fw_mrq[i] = ent[i].mrq;
        end
    end

    assign unused_rd_lsb = ^RD_A[1:0];

    v810_wbuf_fwd #(
        .DEPTH  (DEPTH),
        .FWD_EN (FWD_EN)
    ) u_fwd (
        .ent_wa   (fw_wa),
        .ent_d    (fw_d),
        .ent_be   (fw_be),
        .ent_mrq  (fw_mrq),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .rd_req   (RD_REQ),
        .rd_wa    (RD_A[31:2]),
        .rd_be    (RD_BE),
        .hit      (fw_hit),
        .rd_d     (RD_D),
        .conflict (fw_conflict)
    );

    assign RD_HIT      = RESn & fw_hit;
    assign RD_CONFLICT = RESn & fw_conflict;

endmodule

// File: tb/tb_v810_wbuf.sv
// Bench for v810_wbuf: directed vector table on DEPTH=4, a reset sequence,
// and randomized traffic on DEPTH=4/2/16 against a queue-based model.
module tb_v810_wbuf;

    logic        CLK;
    logic        RESn;
    logic        ce [3];
    logic [31:0] in_a, in_d, rd_a;
    logic [1:0]  in_bc, in_st;
    logic [3:0]  in_be, rd_be;
    logic        in_mrq, in_req, rd_req, out_ack;

    logic        ack_o [3], ov_o [3], omrq_o [3], em_o [3], fu_o [3], hit_o [3], conf_o [3];
    logic [31:0] oa_o [3], od_o [3], rdd_o [3];
    logic [1:0]  obc_o [3], ost_o [3];
    logic [3:0]  obe_o [3];
    logic [2:0]  cnt0;
    logic [1:0]  cnt1;
    logic [4:0]  cnt2;

    int checks = 0;
    int errors = 0;
    int sel = 0;
    int cur_depth = 4;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    v810_wbuf #(.DEPTH(4)) dut4 (
        .CLK(CLK), .RESn(RESn), .CE(ce[0]),
        .IN_A(in_a), .IN_D(in_d), .IN_BC(in_bc), .IN_BE(in_be), .IN_MRQ(in_mrq), .IN_ST(in_st),
        .IN_REQ(in_req), .IN_ACK(ack_o[0]),
        .RD_A(rd_a), .RD_BE(rd_be), .RD_REQ(rd_req), .RD_HIT(hit_o[0]), .RD_D(rdd_o[0]),
        .RD_CONFLICT(conf_o[0]),
        .OUT_A(oa_o[0]), .OUT_D(od_o[0]), .OUT_BC(obc_o[0]), .OUT_BE(obe_o[0]),
        .OUT_MRQ(omrq_o[0]), .OUT_ST(ost_o[0]), .OUT_VALID(ov_o[0]), .OUT_ACK(out_ack),
        .EMPTY(em_o[0]), .FULL(fu_o[0]), .COUNT(cnt0)
    );

    v810_wbuf #(.DEPTH(2)) dut2 (
        .CLK(CLK), .RESn(RESn), .CE(ce[1]),
        .IN_A(in_a), .IN_D(in_d), .IN_BC(in_bc), .IN_BE(in_be), .IN_MRQ(in_mrq), .IN_ST(in_st),
        .IN_REQ(in_req), .IN_ACK(ack_o[1]),
        .RD_A(rd_a), .RD_BE(rd_be), .RD_REQ(rd_req), .RD_HIT(hit_o[1]), .RD_D(rdd_o[1]),
        .RD_CONFLICT(conf_o[1]),
        .OUT_A(oa_o[1]), .OUT_D(od_o[1]), .OUT_BC(obc_o[1]), .OUT_BE(obe_o[1]),
        .OUT_MRQ(omrq_o[1]), .OUT_ST(ost_o[1]), .OUT_VALID(ov_o[1]), .OUT_ACK(out_ack),
        .EMPTY(em_o[1]), .FULL(fu_o[1]), .COUNT(cnt1)
    );

    v810_wbuf #(.DEPTH(16)) dut16 (
        .CLK(CLK), .RESn(RESn), .CE(ce[2]),
        .IN_A(in_a), .IN_D(in_d), .IN_BC(in_bc), .IN_BE(in_be), .IN_MRQ(in_mrq), .IN_ST(in_st),
        .IN_REQ(in_req), .IN_ACK(ack_o[2]),
        .RD_A(rd_a), .RD_BE(rd_be), .RD_REQ(rd_req), .RD_HIT(hit_o[2]), .RD_D(rdd_o[2]),
        .RD_CONFLICT(conf_o[2]),
        .OUT_A(oa_o[2]), .OUT_D(od_o[2]), .OUT_BC(obc_o[2]), .OUT_BE(obe_o[2]),
        .OUT_MRQ(omrq_o[2]), .OUT_ST(ost_o[2]), .OUT_VALID(ov_o[2]), .OUT_ACK(out_ack),
        .EMPTY(em_o[2]), .FULL(fu_o[2]), .COUNT(cnt2)
    );

    // Selected-DUT view of the outputs
    logic        m_ack, m_ov, m_omrq, m_em, m_fu, m_hit, m_conf;
    logic [31:0] m_oa, m_od, m_rdd;
    logic [1:0]  m_obc, m_ost;
    logic [3:0]  m_obe;
    int          m_cnt;

    always_comb begin
        m_ack  = ack_o[sel];  m_ov  = ov_o[sel];  m_omrq = omrq_o[sel];
        m_em   = em_o[sel];   m_fu  = fu_o[sel];  m_hit  = hit_o[sel];
        m_conf = conf_o[sel]; m_oa  = oa_o[sel];  m_od   = od_o[sel];
        m_rdd  = rdd_o[sel];  m_obc = obc_o[sel]; m_ost  = ost_o[sel];
        m_obe  = obe_o[sel];
        case (sel)
            1:       m_cnt = int'(cnt1);
            2:       m_cnt = int'(cnt2);
            default: m_cnt = int'(cnt0);
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (depth %0d, t=%0t): got %h expected %h", nm, cur_depth, $time, act, exp);
        end
    endtask

    typedef struct {
        bit          req;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [1:0]  bc;
        logic [1:0]  st;
        bit          oack;
        bit          rreq;
        logic [31:0] ra;
        logic [3:0]  rbe;
        bit          x_ack;
        int          x_cnt;
        bit          x_hit;
        bit          x_conf;
        logic [31:0] x_rdd;
        bit          x_head;
        logic [31:0] x_oa;
        logic [31:0] x_od;
        logic [3:0]  x_obe;
        logic [1:0]  x_obc;
    } vec_t;

    function automatic vec_t mk(bit req, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                                logic [1:0] bc, logic [1:0] st, bit oack, bit rreq,
                                logic [31:0] ra, logic [3:0] rbe, bit xack, int xcnt,
                                bit xhit, bit xconf, logic [31:0] xrdd);
        vec_t v;
        v.req = req; v.a = a; v.d = d; v.be = be; v.bc = bc; v.st = st;
        v.oack = oack; v.rreq = rreq; v.ra = ra; v.rbe = rbe;
        v.x_ack = xack; v.x_cnt = xcnt; v.x_hit = xhit; v.x_conf = xconf; v.x_rdd = xrdd;
        v.x_head = 0; v.x_oa = '0; v.x_od = '0; v.x_obe = '0; v.x_obc = '0;
        return v;
    endfunction

    function automatic vec_t hd(vec_t vin, logic [31:0] oa, logic [31:0] od,
                                logic [3:0] obe, logic [1:0] obc);
        vec_t v;
        v = vin;
        v.x_head = 1; v.x_oa = oa; v.x_od = od; v.x_obe = obe; v.x_obc = obc;
        return v;
    endfunction

    function automatic bit tb_legal(logic [3:0] be);
        return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  bc;
        logic [3:0]  be;
        logic        mrq;
        logic [1:0]  st;
    } m_ent_t;

    task automatic idle_inputs();
        in_req = 0; in_a = '0; in_d = '0; in_be = '0; in_bc = '0; in_mrq = 1; in_st = '0;
        rd_req = 0; rd_a = '0; rd_be = '0; out_ack = 0;
    endtask

    task automatic run_random(input int s, input int depth, input int ncyc);
        m_ent_t     mq[$];
        m_ent_t     e;
        bit         pop_req, mrg, ack, found, cov;
        int         fi;
        logic [3:0] bor;
        sel = s;
        cur_depth = depth;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) ce[k] = (k == s);
        idle_inputs();
        RESn = 0;
        @(negedge CLK);
        RESn = 1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            ce[s]   = ($urandom_range(0, 9) != 0);
            in_req  = ($urandom_range(0, 9) < 7);
            in_a    = 32'h400 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            in_d    = $urandom;
            in_be   = 4'($urandom_range(0, 15));
            in_bc   = 2'($urandom_range(0, 3));
            in_mrq  = ($urandom_range(0, 3) != 0);
            in_st   = 2'($urandom_range(0, 1));
            out_ack = (c < ncyc / 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rd_req  = 1'($urandom_range(0, 1));
            rd_a    = 32'h400 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            rd_be   = 4'($urandom_range(1, 15));
            #1;
            pop_req = (mq.size() > 0) && out_ack;
            mrg = 0;
            bor = '0;
            if (mq.size() >= 2) begin
                e   = mq[mq.size() - 1];
                bor = e.be | in_be;
                mrg = (e.a[31:2] == in_a[31:2]) && (e.mrq == in_mrq) && (e.st == in_st) && tb_legal(bor);
            end
            ack = in_req && (mrg || (mq.size() < depth) || pop_req);
            chk("rnd IN_ACK", 32'(m_ack), 32'(ack));
            chk("rnd COUNT", 32'(m_cnt), 32'(mq.size()));
            chk("rnd EMPTY", 32'(m_em), 32'(mq.size() == 0));
            chk("rnd FULL", 32'(m_fu), 32'(mq.size() == depth));
            chk("rnd OUT_VALID", 32'(m_ov), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("rnd OUT_A", m_oa, mq[0].a);
                chk("rnd OUT_D", m_od, mq[0].d);
                chk("rnd OUT_BE/BC/MRQ/ST", {23'd0, m_obe, m_obc, m_omrq, m_ost},
                    {23'd0, mq[0].be, mq[0].bc, mq[0].mrq, mq[0].st});
            end
            found = 0;
            fi = 0;
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].mrq && (mq[i].a[31:2] == rd_a[31:2])) begin
                    found = 1;
                    fi = i;
                end
            end
            cov = found && ((mq[fi].be & rd_be) == rd_be);
            chk("rnd RD_HIT", 32'(m_hit), 32'(rd_req && found && cov));
            chk("rnd RD_CONFLICT", 32'(m_conf), 32'(rd_req && found && !cov));
            if (rd_req && found && cov) chk("rnd RD_D", m_rdd, mq[fi].d);
            if (ce[s]) begin
                if (ack && mrg) begin
                    e = mq[mq.size() - 1];
                    for (int b = 0; b < 4; b++) if (in_be[b]) e.d[8*b +: 8] = in_d[8*b +: 8];
                    e.be = bor;
                    e.bc = 2'($countones(bor) - 1);
                    mq[mq.size() - 1] = e;
                end else if (ack) begin
                    mq.push_back('{a: in_a, d: in_d, bc: in_bc, be: in_be, mrq: in_mrq, st: in_st});
                end
                if (pop_req) void'(mq.pop_front());
            end
        end
    endtask

    vec_t vq[$];

    initial begin
        localparam logic [3:0] F = 4'hF;
        idle_inputs();
        RESn = 0;
        for (int k = 0; k < 3; k++) ce[k] = 1;
        sel = 0;

        // Full/blocked/push-with-pop, merge, forward/conflict, youngest-wins
        vq.push_back(mk(1, 'h10, 'h10, F, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 'h20, 'h20, F, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 'h30, 'h30, F, 3, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        vq.push_back(mk(1, 'h40, 'h40, F, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0));
        vq.push_back(mk(1, 'h50, 'h50, F, 3, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0));
        vq.push_back(hd(mk(1, 'h50, 'h50, F, 3, 0, 1, 0, 0, 0, 1, 4, 0, 0, 0), 'h10, 'h10, F, 3));
        vq.push_back(hd(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0), 'h20, 'h20, F, 3));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(1, 'h100, 'h1234, 4'b0011, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 'h200, 'h5678, 4'b0011, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 'h200, 'hABCD0000, 4'b1100, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        vq.push_back(hd(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 'h200, 'hABCD5678, F, 3));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(1, 'h300, 'hDEADBEEF, F, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(hd(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h302, 4'b1100, 0, 1, 1, 0, 'hDEADBEEF),
                        'h300, 'hDEADBEEF, F, 3));
        vq.push_back(mk(1, 'h304, 'hCAFE, 4'b0011, 1, 0, 0, 1, 'h304, F, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h304, F, 0, 2, 0, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h304, 4'b0001, 0, 2, 1, 0, 'hCAFE));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(1, 'h500, 0, F, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 'h400, 'h11111111, F, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 'h400, 'h22222222, F, 3, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h400, F, 0, 3, 1, 0, 'h22222222));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(negedge CLK);
        #1;
        chk("reset EMPTY", 32'(m_em), 32'd1);
        chk("reset FULL", 32'(m_fu), 32'd0);
        chk("reset OUT_VALID", 32'(m_ov), 32'd0);
        chk("reset COUNT", 32'(m_cnt), 32'd0);
        @(negedge CLK);
        RESn = 1;
        ce[1] = 0;
        ce[2] = 0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLK);
            in_req = vq[i].req; in_a = vq[i].a; in_d = vq[i].d; in_be = vq[i].be;
            in_bc = vq[i].bc; in_st = vq[i].st; in_mrq = 1; out_ack = vq[i].oack;
            rd_req = vq[i].rreq; rd_a = vq[i].ra; rd_be = vq[i].rbe;
            #1;
            chk($sformatf("vec%0d IN_ACK", i), 32'(m_ack), 32'(vq[i].x_ack));
            chk($sformatf("vec%0d COUNT", i), 32'(m_cnt), 32'(vq[i].x_cnt));
            chk($sformatf("vec%0d RD_HIT", i), 32'(m_hit), 32'(vq[i].x_hit));
            chk($sformatf("vec%0d RD_CONFLICT", i), 32'(m_conf), 32'(vq[i].x_conf));
            if (vq[i].x_hit) chk($sformatf("vec%0d RD_D", i), m_rdd, vq[i].x_rdd);
            if (vq[i].x_head) begin
                chk($sformatf("vec%0d OUT_A", i), m_oa, vq[i].x_oa);
                chk($sformatf("vec%0d OUT_D", i), m_od, vq[i].x_od);
                chk($sformatf("vec%0d OUT_BE", i), 32'(m_obe), 32'(vq[i].x_obe));
                chk($sformatf("vec%0d OUT_BC", i), 32'(m_obc), 32'(vq[i].x_obc));
            end
        end

        // Reset with three entries queued discards them and masks handshakes
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            idle_inputs();
            in_req = 1; in_a = 32'h600 + 32'(i * 16); in_d = 32'(i); in_be = 4'hF; in_bc = 2'd3;
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        chk("pre-reset COUNT", 32'(m_cnt), 32'd3);
        RESn = 0;
        in_req = 1; in_a = 32'h700; in_be = 4'hF;
        rd_req = 1; rd_a = 32'h600; rd_be = 4'hF;
        #1;
        chk("reset-low IN_ACK", 32'(m_ack), 32'd0);
        chk("reset-low RD_HIT", 32'(m_hit), 32'd0);
        chk("reset-low RD_CONFLICT", 32'(m_conf), 32'd0);
        @(negedge CLK);
        #1;
        chk("reset-mid EMPTY", 32'(m_em), 32'd1);
        chk("reset-mid OUT_VALID", 32'(m_ov), 32'd0);
        chk("reset-mid COUNT", 32'(m_cnt), 32'd0);
        chk("reset-mid FULL", 32'(m_fu), 32'd0);
        chk("reset-mid IN_ACK", 32'(m_ack), 32'd0);
        RESn = 1;
        idle_inputs();

        run_random(0, 4, 300);
        run_random(1, 2, 200);
        run_random(2, 16, 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/v810_wbuf.md
V810_WBUF -- requirements
Module: v810_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of write-buffer slots; power of two, 2..16.
REQ-002 SHALL have parameter MERGE_EN, default 1, enabling byte-merge into the newest non-head entry.
REQ-003 SHALL have parameter FWD_EN, default 1, enabling read-probe forwarding; when 0, RD_HIT=0 and RD_CONFLICT=any address match.
REQ-004 SHALL use one clock and a synchronous, active-low reset: CLK input 1 (system clock); RESn input 1 (synchronous active-low reset).
REQ-005 CE input 1: global clock enable; no state changes when 0.
REQ-006 IN_A/IN_D input 32/32: write address and data; IN_BC input 2 (byte count-1); IN_BE input 4; IN_MRQ input 1; IN_ST input 2.
REQ-007 IN_REQ input 1 (write request); IN_ACK output 1 (write accepted this cycle).
REQ-008 RD_A input 32, RD_BE input 4, RD_REQ input 1: read probe; RD_HIT output 1, RD_D output 32, RD_CONFLICT output 1.
REQ-009 OUT_A/OUT_D output 32/32, OUT_BC output 2, OUT_BE output 4, OUT_MRQ output 1, OUT_ST output 2: head entry.
REQ-010 OUT_VALID output 1 (head present); OUT_ACK input 1 (head consumed).
REQ-011 EMPTY output 1, FULL output 1, COUNT output $clog2(DEPTH)+1 (occupied slots).

Function
REQ-012 SHALL be a circular FIFO of DEPTH entries; pointers $clog2(DEPTH) bits, wrap modulo DEPTH; COUNT, EMPTY, FULL registered.
REQ-013 Pop SHALL occur on a CE cycle with OUT_VALID & OUT_ACK; OUT_* SHALL hold head fields, stable until popped.
REQ-014 Merge condition: MERGE_EN, COUNT>=2, newest entry A[31:2]/MRQ/ST equal to IN_*, and OR'd BE in {0001,0010,0100,1000,0011,1100,1111}.
REQ-015 On merge SHALL set BE=OR of BEs, replace bytes where IN_BE set, BC=popcount(BE)-1; COUNT unchanged.
REQ-016 IN_ACK SHALL be IN_REQ & RESn & (merge | ~FULL | (OUT_VALID & OUT_ACK)); combinational, zero latency.
REQ-017 Non-merge accepted write SHALL push at the write pointer; push and pop in the same cycle leave COUNT unchanged, including when FULL.
REQ-018 Head entry (COUNT=1, or the entry being popped) SHALL never be merge target.
REQ-019 Probe SHALL be combinational over all valid entries, word match on A[31:2] and MRQ=1 on both sides.
REQ-020 RD_HIT SHALL be RD_REQ & youngest match's BE covers RD_BE; RD_D SHALL be that entry's data, else don't-care.
REQ-021 RD_CONFLICT SHALL be RD_REQ & a match exists & ~RD_HIT; RD_HIT and RD_CONFLICT mutually exclusive.
REQ-022 Probe SHALL reflect registered contents only; a same-cycle write is not visible.
REQ-023 IN_BC SHALL be stored verbatim on push; buffer does not validate BC/BE consistency.

Reset
REQ-024 With RESn=0 on a CE edge: pointers 0, COUNT=0, EMPTY=1, FULL=0, OUT_VALID=0.
REQ-025 While RESn=0: IN_ACK=0, RD_HIT=0, RD_CONFLICT=0, regardless of inputs.
REQ-026 Reset mid-operation SHALL discard all entries; slot contents need no reset.

Structure
REQ-027 Entry struct (a, d, bc, be, mrq, st) and the BC/BE-legal-merge function SHALL live in shared package v810_pkg.
REQ-028 Probe logic SHALL be sub-module v810_wbuf_fwd (DEPTH-parametrised, combinational, youngest-first priority).

Verification
REQ-029 DEPTH=4: 4 writes, OUT_ACK=0 -> FULL=1, COUNT=4, 5th IN_REQ gives IN_ACK=0; one OUT_ACK -> 5th accepted same cycle, COUNT=4.
REQ-030 Writes A=0x100 BE=0011 D=0x1234, A=0x200 BE=0011, A=0x200 BE=1100 D=0xABCD0000 -> COUNT=2, second entry BE=1111, BC=3.
REQ-031 Entry A=0x300 BE=1111 D=0xDEADBEEF; probe 0x302 BE=1100 -> RD_HIT=1, RD_D=0xDEADBEEF; probe BE=1111 after entry BE=0011 -> RD_CONFLICT=1.
REQ-032 Two entries at 0x400 (old 0x11111111 BE=1111, young 0x22222222 BE=1111, merge blocked by ST) -> RD_D=0x22222222.
REQ-033 DEPTH=2 and DEPTH=16: 3xDEPTH pushes/pops with random OUT_ACK -> FIFO order preserved across wrap, COUNT matches model.
REQ-034 RESn=0 with COUNT=3 -> next CE edge EMPTY=1, OUT_VALID=0, IN_ACK=0 while low.
